// File: rtl/store_monitor.sv
// Store monitor: logs processor stores into a first-word fall-through trace FIFO
// and decides the run outcome (pass, fail or timeout) from the terminal store address.
module store_monitor #(
    parameter int                 WIDTH          = 32,
    parameter int                 DEPTH          = 8,
    parameter logic [WIDTH-1:0]   PASS_ADDR      = WIDTH'(32'd84),
    parameter logic [WIDTH-1:0]   PASS_DATA      = WIDTH'(32'd7),
    parameter int                 TIMEOUT_CYCLES = 100
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             memwrite,
    input  logic [WIDTH-1:0] dataadr,
    input  logic [WIDTH-1:0] writedata,
    input  logic [WIDTH-1:0] pc,
    input  logic             rd_en,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic             overflow,
    output logic [15:0]      store_count,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic             timeout,
    output logic [WIDTH-1:0] end_pc
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [PW:0]   CNT_ONE  = (PW + 1)'(1);
    localparam logic [PW:0]   CNT_FULL = (PW + 1)'(DEPTH);
    localparam logic [CW-1:0] CYC_ONE  = CW'(1);
    localparam logic [CW-1:0] CYC_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_PASS    = 2'd1,
        ST_FAIL    = 2'd2,
        ST_TIMEOUT = 2'd3
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cycle;
    logic [15:0]      r_store_count;
    logic             r_done;
    logic             r_pass;
    logic             r_fail;
    logic             r_timeout;
    logic [WIDTH-1:0] r_end_pc;

    logic [WIDTH-1:0] r_mem_addr [DEPTH];
    logic [WIDTH-1:0] r_mem_data [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW:0]      r_count;
    logic             r_overflow;

    logic w_run;
    logic w_store;
    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_drop;
    logic w_term;
    logic w_tmo;

    assign w_run   = (r_state == ST_RUN);
    assign w_store = w_run && memwrite;
    assign w_empty = (r_count == {(PW + 1){1'b0}});
    assign w_full  = (r_count == CNT_FULL);
    assign w_pop   = rd_en && !w_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the store.
    assign w_push  = w_store && (!w_full || w_pop);
    assign w_drop  = w_store && w_full && !w_pop;
    assign w_term  = w_store && (dataadr == PASS_ADDR);
    assign w_tmo   = w_run && (r_cycle == CYC_LAST) && !w_term;

    // Run-outcome state machine with registered outcome flags and store counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_RUN;
            r_cycle       <= {CW{1'b0}};
            r_store_count <= 16'd0;
            r_done        <= 1'b0;
            r_pass        <= 1'b0;
            r_fail        <= 1'b0;
            r_timeout     <= 1'b0;
            r_end_pc      <= {WIDTH{1'b0}};
        end else begin
            case (r_state)
                ST_RUN: begin
                    r_cycle <= r_cycle + CYC_ONE;
                    if (memwrite && (r_store_count != 16'hFFFF)) begin
                        r_store_count <= r_store_count + 16'd1;
                    end
                    if (w_term) begin
                        r_end_pc <= pc;
                        r_done   <= 1'b1;
                        if (writedata == PASS_DATA) begin
                            r_state <= ST_PASS;
                            r_pass  <= 1'b1;
                        end else begin
                            r_state <= ST_FAIL;
                            r_fail  <= 1'b1;
                        end
                    end else if (w_tmo) begin
                        r_end_pc  <= pc;
                        r_done    <= 1'b1;
                        r_state   <= ST_TIMEOUT;
                        r_timeout <= 1'b1;
                    end
                end
                ST_PASS, ST_FAIL, ST_TIMEOUT: begin
                    r_state <= r_state;
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

    // Trace FIFO storage; contents need no reset because occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_addr[r_wr_ptr] <= dataadr;
            r_mem_data[r_wr_ptr] <= writedata;
        end
    end

    // Trace FIFO pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= {PW{1'b0}};
            r_rd_ptr   <= {PW{1'b0}};
            r_count    <= {(PW + 1){1'b0}};
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign rd_valid    = !w_empty;
    assign rd_addr     = r_mem_addr[r_rd_ptr];
    assign rd_data     = r_mem_data[r_rd_ptr];
    assign overflow    = r_overflow;
    assign store_count = r_store_count;
    assign done        = r_done;
    assign pass        = r_pass;
    assign fail        = r_fail;
    assign timeout     = r_timeout;
    assign end_pc      = r_end_pc;

endmodule

// File: tb/tb_store_monitor.sv
// Self-checking bench for store_monitor: directed scenarios plus randomized runs,
// all checked every cycle against a queue-based reference model.
module tb_store_monitor;

    localparam int          DEPTH = 8;
    localparam int          TO    = 100;
    localparam logic [31:0] PADDR = 32'd84;
    localparam logic [31:0] PDATA = 32'd7;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        memwrite = 1'b0;
    logic [31:0] dataadr = 32'd0;
    logic [31:0] writedata = 32'd0;
    logic [31:0] pc = 32'd0;
    logic        rd_en = 1'b0;
    logic        rd_valid;
    logic [31:0] rd_addr;
    logic [31:0] rd_data;
    logic        overflow;
    logic [15:0] store_count;
    logic        done;
    logic        pass;
    logic        fail;
    logic        timeout;
    logic [31:0] end_pc;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model: outcome 0=running 1=pass 2=fail 3=timeout.
    logic [63:0] m_q[$];
    int          m_outcome = 0;
    int          m_cyc = 0;
    bit          m_ovf = 1'b0;
    int          m_cnt = 0;
    logic [31:0] m_end_pc = 32'd0;
    logic [31:0] g_pc = 32'h0000_1000;
    logic [31:0] last_pc;

    store_monitor dut (
        .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
        .writedata(writedata), .pc(pc), .rd_en(rd_en), .rd_valid(rd_valid),
        .rd_addr(rd_addr), .rd_data(rd_data), .overflow(overflow),
        .store_count(store_count), .done(done), .pass(pass), .fail(fail),
        .timeout(timeout), .end_pc(end_pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        bit pop;
        bit push;
        pop  = 1'b0;
        push = 1'b0;
        if (reset) begin
            m_q.delete();
            m_outcome = 0;
            m_cyc     = 0;
            m_ovf     = 1'b0;
            m_cnt     = 0;
            m_end_pc  = 32'd0;
        end else begin
            pop = rd_en && (m_q.size() > 0);
            if (m_outcome == 0) begin
                if (memwrite) begin
                    if (m_cnt < 65535) m_cnt++;
                    if (m_q.size() == DEPTH && !pop) m_ovf = 1'b1;
                    else push = 1'b1;
                end
                if (memwrite && dataadr == PADDR) begin
                    m_outcome = (writedata == PDATA) ? 1 : 2;
                    m_end_pc  = pc;
                end else if (m_cyc == TO - 1) begin
                    m_outcome = 3;
                    m_end_pc  = pc;
                end
                m_cyc++;
            end
            if (pop) void'(m_q.pop_front());
            if (push) m_q.push_back({dataadr, writedata});
        end
    endtask

    task automatic compare_all();
        logic [63:0] head;
        check("rd_valid", {31'd0, rd_valid}, {31'd0, m_q.size() > 0});
        if (m_q.size() > 0) begin
            head = m_q[0];
            check("rd_addr", rd_addr, head[63:32]);
            check("rd_data", rd_data, head[31:0]);
        end
        check("overflow", {31'd0, overflow}, {31'd0, m_ovf});
        check("store_count", {16'd0, store_count}, m_cnt);
        check("done", {31'd0, done}, {31'd0, m_outcome != 0});
        check("pass", {31'd0, pass}, {31'd0, m_outcome == 1});
        check("fail", {31'd0, fail}, {31'd0, m_outcome == 2});
        check("timeout", {31'd0, timeout}, {31'd0, m_outcome == 3});
        check("end_pc", end_pc, m_end_pc);
    endtask

    task automatic cyc(input bit rst, input bit mw, input logic [31:0] a,
                       input logic [31:0] d, input bit re);
        g_pc      = g_pc + 32'd4;
        last_pc   = g_pc;
        reset     = rst;
        memwrite  = mw;
        dataadr   = a;
        writedata = d;
        pc        = g_pc;
        rd_en     = re;
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, $urandom, $urandom, 1'b0);
    endtask

    task automatic st(input logic [31:0] a, input logic [31:0] d, input bit re);
        cyc(1'b0, 1'b1, a, d, re);
    endtask

    task automatic pop_n(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
    endtask

    initial begin
        logic [31:0] pc_term;

        // Reset state.
        do_reset();
        check("rst_valid", {31'd0, rd_valid}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);

        // Pass run: stores at cycles 2 and 3, then drain.
        idle(2);
        st(32'h50, 32'd3, 1'b0);
        st(32'h54, 32'd7, 1'b0);
        pc_term = last_pc;
        check("tp1_pass", {31'd0, pass}, 32'd1);
        check("tp1_done", {31'd0, done}, 32'd1);
        check("tp1_count", {16'd0, store_count}, 32'd2);
        check("tp1_endpc", end_pc, pc_term);
        check("tp1_head0", rd_addr, 32'h50);
        check("tp1_data0", rd_data, 32'd3);
        pop_n(1);
        check("tp1_head1", rd_addr, 32'h54);
        check("tp1_data1", rd_data, 32'd7);
        pop_n(1);
        check("tp1_empty", {31'd0, rd_valid}, 32'd0);

        // Fail run: later stores ignored.
        do_reset();
        idle(4);
        st(32'd84, 32'd5, 1'b0);
        check("tp2_fail", {31'd0, fail}, 32'd1);
        check("tp2_pass", {31'd0, pass}, 32'd0);
        check("tp2_tmo", {31'd0, timeout}, 32'd0);
        st(32'h60, 32'd9, 1'b0);
        check("tp2_count", {16'd0, store_count}, 32'd1);

        // Timeout on the edge ending cycle 99.
        do_reset();
        idle(TO - 1);
        check("tp3_notyet", {31'd0, done}, 32'd0);
        idle(1);
        pc_term = last_pc;
        check("tp3_tmo", {31'd0, timeout}, 32'd1);
        check("tp3_done", {31'd0, done}, 32'd1);
        check("tp3_endpc", end_pc, pc_term);

        // Terminal store in the timeout cycle wins.
        do_reset();
        idle(TO - 1);
        st(32'd84, 32'd7, 1'b0);
        check("tp4_pass", {31'd0, pass}, 32'd1);
        check("tp4_tmo", {31'd0, timeout}, 32'd0);

        // Overflow: 10 stores into 8 entries.
        do_reset();
        for (int i = 0; i < 10; i++) st(32'h100 + 32'(4 * i), 32'(i), 1'b0);
        check("tp5_ovf", {31'd0, overflow}, 32'd1);
        check("tp5_count", {16'd0, store_count}, 32'd10);
        check("tp5_head", rd_addr, 32'h100);
        pop_n(7);
        check("tp5_last", rd_addr, 32'h11C);
        pop_n(1);
        check("tp5_empty", {31'd0, rd_valid}, 32'd0);

        // Full FIFO with simultaneous push and pop.
        do_reset();
        for (int i = 0; i < 8; i++) st(32'h200 + 32'(4 * i), 32'(i), 1'b0);
        st(32'h300, 32'd77, 1'b1);
        check("tp6_ovf", {31'd0, overflow}, 32'd0);
        check("tp6_head", rd_addr, 32'h204);
        pop_n(8);
        check("tp6_empty", {31'd0, rd_valid}, 32'd0);

        // Mid-run reset; counter restart is exercised by the following timeout.
        do_reset();
        for (int i = 0; i < 3; i++) st(32'h40 + 32'(4 * i), 32'(i), 1'b0);
        do_reset();
        check("tp7_valid", {31'd0, rd_valid}, 32'd0);
        check("tp7_count", {16'd0, store_count}, 32'd0);
        check("tp7_done", {31'd0, done}, 32'd0);
        idle(TO - 1);
        check("tp7_notyet", {31'd0, done}, 32'd0);
        idle(1);
        check("tp7_tmo", {31'd0, timeout}, 32'd1);

        // Randomized runs against the model.
        for (int r = 0; r < 8; r++) begin
            do_reset();
            for (int k = 0; k < 180; k++) begin
                if ($urandom_range(0, 249) == 0) begin
                    do_reset();
                end else begin
                    cyc(1'b0,
                        $urandom_range(0, 9) < 5,
                        ($urandom_range(0, 39) == 0) ? PADDR : 32'($urandom_range(0, 63)) * 32'd4,
                        ($urandom_range(0, 1) == 1) ? PDATA : 32'($urandom_range(0, 15)),
                        $urandom_range(0, 3) == 0);
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
